// File: rtl/txwregif_wr_arb.sv
// Round-robin arbiter that lets NREQ requesters share one FIFO write port.
// Each grant writes an address word and then a data word back to back.
module txwregif_wr_arb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PTR   = 2,
  parameter int NREQ  = 3
) (
  input  logic                    wrclk,
  input  logic                    reset_,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ack,
  output logic [NREQ-1:0]         grant,
  output logic                    fifo_wren,
  output logic [WIDTH-1:0]        fifo_datain,
  input  logic                    fifo_wrfull,
  input  logic [PTR:0]            fifo_wrusedw,
  output logic                    busy,
  output logic                    err_ovf,
  output logic [15:0]             txn_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR:0] ADMIT_MAX = (PTR+1)'(DEPTH - 2);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     win;
  logic              found;
  logic              admit;
  int unsigned       idx;
  logic [WIDTH-1:0]  sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic [WIDTH-1:0]  data_lat;

  // Search starts one past the previous owner; the previous owner is tried last.
  always_comb begin
    found = 1'b0;
    win   = last_grant;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_grant) + k) % NREQ;
      if (!found && req_valid[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        sel_addr = req_addr[i*WIDTH +: WIDTH];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Two free slots are needed so the data word can never be refused.
  assign admit = found && !fifo_wrfull && (fifo_wrusedw <= ADMIT_MAX);
  assign busy  = (state != IDLE);

  // The address word is driven straight from the winner's inputs on the grant
  // edge, so only the data word needs to be held until the following cycle.
  always_ff @(posedge wrclk) begin
    if (!reset_) begin
      state       <= IDLE;
      grant       <= '0;
      req_ack     <= '0;
      fifo_wren   <= 1'b0;
      fifo_datain <= '0;
      err_ovf     <= 1'b0;
      txn_cnt     <= '0;
      last_grant  <= IW'(NREQ - 1);
      data_lat    <= '0;
    end else begin
      req_ack <= '0;
      if (fifo_wren && fifo_wrfull)
        err_ovf <= 1'b1;
      case (state)
        IDLE: begin
          fifo_wren <= 1'b0;
          if (admit) begin
            state       <= ADDR;
            grant       <= NREQ'(1) << win;
            last_grant  <= win;
            data_lat    <= sel_data;
            fifo_wren   <= 1'b1;
            fifo_datain <= sel_addr;
          end
        end
        ADDR: begin
          state       <= DATA;
          fifo_datain <= data_lat;
          req_ack     <= grant;
          txn_cnt     <= txn_cnt + 16'd1;
        end
        DATA: begin
          state     <= IDLE;
          fifo_wren <= 1'b0;
          grant     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_txwregif_wr_arb.sv
// Scoreboard bench for txwregif_wr_arb: expected FIFO words and acks are
// queued by the stimulus and consumed by a monitor on the falling edge.
module tb_txwregif_wr_arb;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int PTR   = 2;
  localparam int NREQ  = 3;

  logic                  wrclk = 1'b0;
  logic                  reset_;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ack;
  logic [NREQ-1:0]       grant;
  logic                  fifo_wren;
  logic [WIDTH-1:0]      fifo_datain;
  logic                  fifo_wrfull;
  logic [PTR:0]          fifo_wrusedw;
  logic                  busy;
  logic                  err_ovf;
  logic [15:0]           txn_cnt;

  txwregif_wr_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR), .NREQ(NREQ)) dut (
    .wrclk(wrclk), .reset_(reset_), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ack(req_ack), .grant(grant), .fifo_wren(fifo_wren),
    .fifo_datain(fifo_datain), .fifo_wrfull(fifo_wrfull), .fifo_wrusedw(fifo_wrusedw),
    .busy(busy), .err_ovf(err_ovf), .txn_cnt(txn_cnt)
  );

  always #5 wrclk = ~wrclk;

  typedef struct { logic [15:0] word; logic [2:0] gnt; } word_t;
  typedef struct { logic [2:0] ack; logic [15:0] cnt; } ack_t;

  word_t wq[$];
  ack_t  aq[$];
  int    checks = 0;
  int    passed = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endfunction

  // Monitor: every FIFO write and every ack must match the head of its queue.
  always @(negedge wrclk) begin
    word_t w;
    ack_t  a;
    if (fifo_wren === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got %0h required no write", fifo_datain);
      end else begin
        w = wq.pop_front();
        check("fifo_datain", 32'(fifo_datain), 32'(w.word));
        check("grant_at_write", 32'(grant), 32'(w.gnt));
      end
    end
    if ((|req_ack) === 1'b1) begin
      if (aq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ack: got %b required no ack", req_ack);
      end else begin
        a = aq.pop_front();
        check("req_ack", 32'(req_ack), 32'(a.ack));
        check("txn_cnt_at_ack", 32'(txn_cnt), 32'(a.cnt));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge wrclk);
    #1;
  endtask

  task automatic push_txn(input int r, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] cnt);
    word_t w;
    ack_t  k;
    logic [2:0] g;
    g = 3'b001 << r;
    req_addr[r*WIDTH +: WIDTH] = a;
    req_data[r*WIDTH +: WIDTH] = d;
    w.word = a; w.gnt = g; wq.push_back(w);
    w.word = d; w.gnt = g; wq.push_back(w);
    k.ack = g; k.cnt = cnt; aq.push_back(k);
  endtask

  task automatic wait_ack(input logic [2:0] mask, output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge wrclk);
      if ((req_ack & mask) != 3'b000) begin
        got = 1'b1;
        cycles = i;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL ack_timeout: got no ack required %b", mask);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cy;
    bit seen;
    reset_ = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    fifo_wrfull = 1'b0; fifo_wrusedw = '0;

    // Reset state
    cyc(3);
    @(negedge wrclk);
    check("rst_grant", 32'(grant), 0);
    check("rst_ack", 32'(req_ack), 0);
    check("rst_wren", 32'(fifo_wren), 0);
    check("rst_datain", 32'(fifo_datain), 0);
    check("rst_err", 32'(err_ovf), 0);
    check("rst_cnt", 32'(txn_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    cyc(1);
    reset_ = 1'b1;

    // Single request with fixed latency
    push_txn(0, 16'h0010, 16'hBEEF, 16'd1);
    cyc(1);
    req_valid = 3'b001;
    @(negedge wrclk);
    check("n_wren", 32'(fifo_wren), 0);
    check("n_busy", 32'(busy), 0);
    @(negedge wrclk);
    check("n1_wren", 32'(fifo_wren), 1);
    check("n1_busy", 32'(busy), 1);
    @(negedge wrclk);
    check("n2_ack", 32'(req_ack), 32'h1);
    check("n2_cnt", 32'(txn_cnt), 1);
    req_valid = 3'b000;
    @(negedge wrclk);
    check("n3_busy", 32'(busy), 0);
    check("n3_wren", 32'(fifo_wren), 0);
    check("n3_ack", 32'(req_ack), 0);

    // All requesters valid after reset: order 0,1,2,0, ack every 3 cycles
    cyc(1);
    reset_ = 1'b0;
    cyc(2);
    reset_ = 1'b1;
    push_txn(0, 16'h0100, 16'hD000, 16'd1);
    push_txn(1, 16'h0101, 16'hD001, 16'd2);
    push_txn(2, 16'h0102, 16'hD002, 16'd3);
    push_txn(0, 16'h0100, 16'hD000, 16'd4);
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(3'b111, cy);
      check("rr_ack_spacing", 32'(cy), 3);
    end
    req_valid = 3'b000;

    // Admission limit on used-word count
    cyc(1);
    fifo_wrusedw = 3'd3;
    push_txn(1, 16'h0A0A, 16'h0B0B, 16'd5);
    req_valid = 3'b010;
    for (int k = 0; k < 4; k++) begin
      @(negedge wrclk);
      check("full_grant", 32'(grant), 0);
      check("full_wren", 32'(fifo_wren), 0);
    end
    cyc(1);
    fifo_wrusedw = 3'd2;
    wait_ack(3'b010, cy);
    check("admit_latency", 32'(cy), 3);
    req_valid = 3'b000;
    fifo_wrusedw = 3'd0;

    // Forced overflow during DATA, sticky across a later transaction
    cyc(1);
    check("pre_ovf", 32'(err_ovf), 0);
    push_txn(2, 16'h2222, 16'h3333, 16'd6);
    req_valid = 3'b100;
    wait_ack(3'b100, cy);
    fifo_wrfull = 1'b1;
    req_valid = 3'b000;
    cyc(1);
    fifo_wrfull = 1'b0;
    @(negedge wrclk);
    check("ovf_set", 32'(err_ovf), 1);
    cyc(1);
    push_txn(0, 16'h4444, 16'h5555, 16'd7);
    req_valid = 3'b001;
    wait_ack(3'b001, cy);
    req_valid = 3'b000;
    @(negedge wrclk);
    check("ovf_sticky", 32'(err_ovf), 1);

    // Reset while in ADDR aborts the transaction
    cyc(1);
    req_addr[1*WIDTH +: WIDTH] = 16'h6666;
    req_data[1*WIDTH +: WIDTH] = 16'h7777;
    begin
      word_t w;
      w.word = 16'h6666; w.gnt = 3'b010; wq.push_back(w);
    end
    req_valid = 3'b010;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge wrclk);
      if (fifo_wren === 1'b1) seen = 1'b1;
    end
    check("addr_phase_seen", 32'(seen), 1);
    reset_ = 1'b0;
    cyc(1);
    reset_ = 1'b1;
    req_valid = 3'b000;
    @(negedge wrclk);
    check("abort_busy", 32'(busy), 0);
    check("abort_wren", 32'(fifo_wren), 0);
    check("abort_ack", 32'(req_ack), 0);
    check("abort_cnt", 32'(txn_cnt), 0);
    check("abort_ovf", 32'(err_ovf), 0);
    check("abort_grant", 32'(grant), 0);
    cyc(1);
    push_txn(0, 16'h8888, 16'h9999, 16'd1);
    push_txn(1, 16'h6666, 16'h7777, 16'd2);
    req_valid = 3'b011;
    wait_ack(3'b001, cy);
    check("post_rst_r0_latency", 32'(cy), 3);
    req_valid[0] = 1'b0;
    wait_ack(3'b010, cy);
    check("post_rst_r1_spacing", 32'(cy), 3);
    req_valid[1] = 1'b0;

    // Counter wrap from 0xFFFF
    cyc(1);
    force dut.txn_cnt = 16'hFFFF;
    cyc(1);
    release dut.txn_cnt;
    push_txn(2, 16'hAAAA, 16'hBBBB, 16'h0000);
    req_valid = 3'b100;
    wait_ack(3'b100, cy);
    req_valid = 3'b000;
    @(negedge wrclk);
    check("wrap_cnt", 32'(txn_cnt), 0);

    repeat (3) @(negedge wrclk);
    check("words_left", 32'(wq.size()), 0);
    check("acks_left", 32'(aq.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
